// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC manual time-set block.
// Holds the set-FSM state enum, the BCD time record, the parameter defaults
// and a BCD increment helper used by the edit registers.
package rtc_pkg;

    localparam int DEBOUNCE_DEPTH_DFLT = 8;
    localparam int REPEAT_DELAY_DFLT   = 500;
    localparam int REPEAT_RATE_DFLT    = 100;

    // Button bit positions inside push_button.
    localparam int BTN_SS = 0;
    localparam int BTN_MM = 1;
    localparam int BTN_HH = 2;

    // Wrap points of the two-digit fields, in BCD.
    localparam logic [7:0] HOURS_MAX  = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_EDIT    = 2'd2,
        ST_COMMIT  = 2'd3
    } rtc_state_e;

    typedef struct packed {
        logic [3:0] hh1;
        logic [3:0] hh0;
        logic [3:0] mm1;
        logic [3:0] mm0;
        logic [3:0] ss1;
        logic [3:0] ss0;
    } bcd_time_t;

    // Two-digit BCD increment that wraps to 00 after max_val, never carrying out.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
        logic [7:0] res;
        if (val == max_val) begin
            res = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/rtc_debounce.sv
// Synchronizer + sample-tick debouncer for one slow input.
// Ports:
//   i_clk, i_rst      : clock and synchronous active-high reset
//   i_tick            : one-cycle sample enable
//   i_raw             : asynchronous raw input (IDLE_LVL is its released/off level)
//   o_active          : debounced level, 1 = away from IDLE_LVL (pressed/on)
//   o_active_nxt      : value o_active takes at the next edge
//   o_press           : one-cycle pulse on the cycle after the tick that activates
module rtc_debounce
    import rtc_pkg::*;
#(
    parameter int   DEPTH    = DEBOUNCE_DEPTH_DFLT,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_active,
    output logic o_active_nxt,
    output logic o_press
);

    localparam logic [DEPTH-1:0] ALL_IDLE = {DEPTH{IDLE_LVL}};

    logic [1:0]       r_sync;
    logic [DEPTH-1:0] r_shift;
    logic             r_active;
    logic             r_press;
    logic [DEPTH-1:0] w_shift_nxt;
    logic             w_all_idle;
    logic             w_all_act;
    logic             w_active_nxt;

    // Next debounced level: flips only when a tick fills the window with the opposite value.
    always_comb begin
        w_shift_nxt  = {r_shift[DEPTH-2:0], r_sync[1]};
        w_all_idle   = (w_shift_nxt == ALL_IDLE);
        w_all_act    = (w_shift_nxt == ~ALL_IDLE);
        w_active_nxt = r_active;
        if (i_tick) begin
            if (w_all_act) begin
                w_active_nxt = 1'b1;
            end else if (w_all_idle) begin
                w_active_nxt = 1'b0;
            end else begin
                w_active_nxt = r_active;
            end
        end else begin
            w_active_nxt = r_active;
        end
    end

    // Synchronizer, sample window, debounced level and activation pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= {2{IDLE_LVL}};
            r_shift  <= ALL_IDLE;
            r_active <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (i_tick) begin
                r_shift <= w_shift_nxt;
            end else begin
                r_shift <= r_shift;
            end
            r_active <= w_active_nxt;
            r_press  <= w_active_nxt & ~r_active;
        end
    end

    assign o_active     = r_active;
    assign o_active_nxt = w_active_nxt;
    assign o_press      = r_press;

endmodule

// File: rtl/rtc_time_set.sv
// Manual time-set front end for an RTC.
// Debounces three active-low buttons (hours/minutes/seconds) and the manual
// switch, adds press-and-hold auto-repeat, and runs a RUN/CAPTURE/EDIT/COMMIT
// FSM that snapshots the running time, lets the user bump each field, then
// offers the edited time to the counters with a valid/ready handshake.
// Ports:
//   clk50M, reset        : sole clock, synchronous active-high reset
//   sample_tick          : 1 kHz one-cycle debounce sample enable
//   push_button[2:0]     : active-low buttons, [2] hours [1] minutes [0] seconds
//   man_switch           : 1 = manual set mode
//   cur_*                : running time, BCD
//   set_*                : edited time, BCD (always the edit registers)
//   load_valid/ready     : load handshake toward the counters
//   setting              : high while editing
module rtc_time_set
    import rtc_pkg::*;
#(
    parameter int DEBOUNCE_DEPTH = DEBOUNCE_DEPTH_DFLT,
    parameter int REPEAT_DELAY   = REPEAT_DELAY_DFLT,
    parameter int REPEAT_RATE    = REPEAT_RATE_DFLT
) (
    input  logic       clk50M,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic [2:0] push_button,
    input  logic       man_switch,
    input  logic [3:0] cur_hh1,
    input  logic [3:0] cur_hh0,
    input  logic [3:0] cur_mm1,
    input  logic [3:0] cur_mm0,
    input  logic [3:0] cur_ss1,
    input  logic [3:0] cur_ss0,
    output logic [3:0] set_hh1,
    output logic [3:0] set_hh0,
    output logic [3:0] set_mm1,
    output logic [3:0] set_mm0,
    output logic [3:0] set_ss1,
    output logic [3:0] set_ss0,
    output logic       load_valid,
    input  logic       load_ready,
    output logic       setting
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = $clog2(REP_MAX + 1);

    logic [2:0]    w_held;
    logic [2:0]    w_held_nxt;
    logic [2:0]    w_deb_press;
    logic [2:0]    w_press;
    logic          w_man_on;
    logic          w_man_nxt_unused;
    logic          w_man_press_unused;

    logic [CW-1:0] r_rep_cnt [3];
    logic [2:0]    r_rep_phase;
    logic [2:0]    r_rep_press;
    rtc_state_e    r_state;
    bcd_time_t     r_edit;
    logic          r_load_valid;
    logic          r_setting;

    genvar g;
    for (g = 0; g < 3; g++) begin : g_btn
        rtc_debounce #(.DEPTH(DEBOUNCE_DEPTH), .IDLE_LVL(1'b1)) u_deb (
            .i_clk        (clk50M),
            .i_rst        (reset),
            .i_tick       (sample_tick),
            .i_raw        (push_button[g]),
            .o_active     (w_held[g]),
            .o_active_nxt (w_held_nxt[g]),
            .o_press      (w_deb_press[g])
        );
    end

    rtc_debounce #(.DEPTH(DEBOUNCE_DEPTH), .IDLE_LVL(1'b0)) u_deb_man (
        .i_clk        (clk50M),
        .i_rst        (reset),
        .i_tick       (sample_tick),
        .i_raw        (man_switch),
        .o_active     (w_man_on),
        .o_active_nxt (w_man_nxt_unused),
        .o_press      (w_man_press_unused)
    );

    // Auto-repeat: count ticks only while a button was held before and stays held after
    // the tick, so a press edge or a release on the same tick restarts the count.
    always_ff @(posedge clk50M) begin
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                r_rep_cnt[b] <= '0;
            end
            r_rep_phase <= 3'b000;
            r_rep_press <= 3'b000;
        end else begin
            for (int b = 0; b < 3; b++) begin
                r_rep_press[b] <= 1'b0;
                if (!w_held[b] || !w_held_nxt[b]) begin
                    r_rep_cnt[b]   <= '0;
                    r_rep_phase[b] <= 1'b0;
                end else if (sample_tick) begin
                    if (!r_rep_phase[b] && (r_rep_cnt[b] == CW'(REPEAT_DELAY - 1))) begin
                        r_rep_press[b] <= 1'b1;
                        r_rep_cnt[b]   <= '0;
                        r_rep_phase[b] <= 1'b1;
                    end else if (r_rep_phase[b] && (r_rep_cnt[b] == CW'(REPEAT_RATE - 1))) begin
                        r_rep_press[b] <= 1'b1;
                        r_rep_cnt[b]   <= '0;
                    end else begin
                        r_rep_cnt[b] <= r_rep_cnt[b] + CW'(1);
                    end
                end else begin
                    r_rep_cnt[b] <= r_rep_cnt[b];
                end
            end
        end
    end

    assign w_press = w_deb_press | r_rep_press;

    // Set FSM with the edit registers and registered handshake/status outputs.
    always_ff @(posedge clk50M) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_edit       <= '0;
            r_load_valid <= 1'b0;
            r_setting    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_load_valid <= 1'b0;
                    r_setting    <= 1'b0;
                    if (w_man_on) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_CAPTURE: begin
                    r_edit    <= '{cur_hh1, cur_hh0, cur_mm1, cur_mm0, cur_ss1, cur_ss0};
                    r_setting <= 1'b1;
                    r_state   <= ST_EDIT;
                end
                ST_EDIT: begin
                    // Fields are independent: each button only touches its own pair.
                    if (w_press[BTN_HH]) begin
                        {r_edit.hh1, r_edit.hh0} <= bcd_inc({r_edit.hh1, r_edit.hh0}, HOURS_MAX);
                    end
                    if (w_press[BTN_MM]) begin
                        {r_edit.mm1, r_edit.mm0} <= bcd_inc({r_edit.mm1, r_edit.mm0}, MINSEC_MAX);
                    end
                    if (w_press[BTN_SS]) begin
                        {r_edit.ss1, r_edit.ss0} <= bcd_inc({r_edit.ss1, r_edit.ss0}, MINSEC_MAX);
                    end
                    if (!w_man_on) begin
                        r_setting    <= 1'b0;
                        r_load_valid <= 1'b1;
                        r_state      <= ST_COMMIT;
                    end else begin
                        r_state <= ST_EDIT;
                    end
                end
                ST_COMMIT: begin
                    // The switch is ignored here; the handshake always completes first.
                    if (load_ready) begin
                        r_load_valid <= 1'b0;
                        r_state      <= ST_RUN;
                    end else begin
                        r_state <= ST_COMMIT;
                    end
                end
                default: begin
                    r_state      <= ST_RUN;
                    r_load_valid <= 1'b0;
                    r_setting    <= 1'b0;
                end
            endcase
        end
    end

    assign set_hh1    = r_edit.hh1;
    assign set_hh0    = r_edit.hh0;
    assign set_mm1    = r_edit.mm1;
    assign set_mm0    = r_edit.mm0;
    assign set_ss1    = r_edit.ss1;
    assign set_ss0    = r_edit.ss0;
    assign load_valid = r_load_valid;
    assign setting    = r_setting;

endmodule

// File: doc/rtc_time_set.md
RTC_TIME_SET -- requirements
Module: rtc_time_set

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_DEPTH, default 8: the number of consecutive equal samples needed to change a debounced level.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 500: the number of sample ticks a button is held before auto-repeat starts.
REQ-003 The block SHALL have parameter REPEAT_RATE, default 100: the number of sample ticks between auto-repeat pulses.
REQ-004 The block SHALL have port clk50M, input, 1 bit: the 50 MHz clock, which is the only clock.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port sample_tick, input, 1 bit: a one-cycle 1 kHz debounce sample enable.
REQ-007 The block SHALL have port push_button, input, 3 bits, active-low: [2] hours, [1] minutes, [0] seconds.
REQ-008 The block SHALL have port man_switch, input, 1 bit: 1 selects manual set mode.
REQ-009 The block SHALL have ports cur_hh1, cur_hh0, cur_mm1, cur_mm0, cur_ss1, cur_ss0, each input, 4 bits: the running time in BCD.
REQ-010 The block SHALL have ports set_hh1, set_hh0, set_mm1, set_mm0, set_ss1, set_ss0, each output, 4 bits: the edited time in BCD.
REQ-011 The block SHALL have port load_valid, output, 1 bit: the set_* value is offered to the counters.
REQ-012 The block SHALL have port load_ready, input, 1 bit: the counters accept the load.
REQ-013 The block SHALL have port setting, output, 1 bit: high while in EDIT.

Function
REQ-014 push_button and man_switch SHALL each pass through a 2-flop synchronizer and then a debouncer.
REQ-015 Each debouncer SHALL shift in its synced input only on sample_tick; its debounced level changes only when all DEBOUNCE_DEPTH samples equal the opposite value.
REQ-016 On a button's debounced released-to-pressed transition, a one-cycle press pulse SHALL assert on the cycle after the qualifying sample_tick.
REQ-017 While a button stays pressed, further press pulses SHALL fire REPEAT_DELAY ticks after the first pulse and then every REPEAT_RATE ticks; the repeat counter clears on release.
REQ-018 The FSM SHALL have states RUN, CAPTURE, EDIT and COMMIT.
REQ-019 RUN: setting=0 and load_valid=0; when debounced man_switch=1, go to CAPTURE.
REQ-020 CAPTURE: lasts one cycle, copies cur_* into the edit registers, then goes to EDIT.
REQ-021 EDIT: setting=1; each press pulse increments its field on the following cycle; debounced man_switch=0 goes to COMMIT.
REQ-022 The seconds and minutes fields SHALL count 00 to 59 and wrap to 00; the hours field SHALL count 00 to 23 and wrap to 00.
REQ-023 No field SHALL carry into any other field.
REQ-024 Simultaneous press pulses SHALL update all affected fields in the same cycle.
REQ-025 COMMIT: load_valid=1 with set_* held stable; on the cycle where load_valid and load_ready are both 1, load_valid deasserts on the next cycle and the FSM goes to RUN.
REQ-026 man_switch returning to 1 during COMMIT SHALL NOT abort the handshake; the FSM re-enters CAPTURE via RUN afterwards.
REQ-027 Press pulses outside EDIT SHALL be ignored.
REQ-028 set_* SHALL always reflect the edit registers and SHALL hold their value in RUN.
REQ-029 Each edit register SHALL hold valid BCD at all times; cur_* values are assumed valid BCD.

Reset
REQ-030 While reset=1 on a clk50M edge, the FSM SHALL go to RUN and set_* SHALL be 0.
REQ-031 While reset=1 on a clk50M edge, load_valid and setting SHALL be 0.
REQ-032 While reset=1 on a clk50M edge, the synchronizers and shift registers SHALL load the released/off level, and the repeat counters SHALL clear.
REQ-033 Reset asserted mid-COMMIT SHALL drop load_valid on the next cycle with no load implied.

Structure
REQ-034 Package rtc_pkg SHALL hold the FSM state enum, a BCD time struct, and the parameter defaults.
REQ-035 Sub-module rtc_debounce (synchronizer, shift register, level and pulse output) SHALL be instantiated 4 times: 3 buttons plus man_switch.
REQ-036 The auto-repeat logic and the FSM SHALL reside in rtc_time_set.

Verification
REQ-037 Scenario: assert reset for 2 cycles -> all outputs 0, state RUN.
REQ-038 Scenario: minutes button bounces every tick for 5 ticks, then is held low for 8 ticks -> exactly one increment, 12:34 -> 12:35.
REQ-039 Scenario: cur=23:59:58, enter manual, one hours press, leave manual, hold load_ready=0 for 3 cycles -> load_valid stays high with set=00:59:58, then drops the cycle after ready.
REQ-040 Scenario: seconds field at 59, one seconds press -> 00 with minutes unchanged.
REQ-041 Scenario: minutes field at 00, button held for 500+3*100 ticks -> 04.
REQ-042 Scenario: 12:34:56, all three buttons pressed together -> 13:35:57.
